// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: LCD test-pattern source for the RGB panel path.
// Takes pixel coordinates and DE from the LCD timing driver and returns one
// RGB pixel per DE cycle after a fixed two-cycle latency. Eight patterns are
// available. The mode is either taken from mode_sel or auto-cycled on a frame
// count, and it only changes on frame_start, so no frame is ever split.
//
// Pixel flow: there is no back-pressure. lcd_de qualifies lcd_xpos and
// lcd_ypos in the cycle they are presented. lcd_data_vld is that same DE
// delayed by exactly two cycles. lcd_data is zero whenever lcd_data_vld is
// low, so the panel never sees stale colour between lines.
module lcd_pattern_gen #(
    parameter int H_DISP       = 800,
    parameter int V_DISP       = 480,
    parameter int COLOR_W      = 8,
    parameter int DWELL_FRAMES = 120,
    parameter int CHECK_LOG2   = 5,
    parameter int BAR_W        = 32,
    parameter int BAR_STEP     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [11:0]            lcd_xpos,
    input  logic [11:0]            lcd_ypos,
    input  logic                   lcd_de,
    input  logic                   frame_start,
    input  logic                   auto_en,
    input  logic [2:0]             mode_sel,
    input  logic                   mode_step,
    output logic [3*COLOR_W-1:0]   lcd_data,
    output logic                   lcd_data_vld,
    output logic [2:0]             cur_mode
);

    localparam int PIX_W   = 3 * COLOR_W;
    localparam int PROD_W  = (PIX_W > 24) ? PIX_W : 24;
    localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);
    localparam logic [11:0]        H_LIM      = 12'(H_DISP);
    localparam logic [11:0]        V_LIM      = 12'(V_DISP);
    localparam logic [11:0]        H_LAST     = 12'(H_DISP - 1);
    localparam logic [11:0]        V_LAST     = 12'(V_DISP - 1);
    localparam logic [11:0]        H_MID      = 12'(H_DISP / 2);
    localparam logic [11:0]        V_MID      = 12'(V_DISP / 2);
    localparam logic [12:0]        H_LIM13    = 13'(H_DISP);
    localparam logic [12:0]        BAR_STEP13 = 13'(BAR_STEP);
    localparam logic [12:0]        BAR_W13    = 13'(BAR_W);

    // Fixed eight-colour palette, index order shared by the bar patterns
    // and the solid-cycle pattern.
    function automatic logic [PIX_W-1:0] palette(input logic [2:0] idx);
        logic [COLOR_W-1:0] f;
        logic [COLOR_W-1:0] z;
        f = '1;
        z = '0;
        case (idx)
            3'd0:    palette = {f, z, z};
            3'd1:    palette = {z, f, z};
            3'd2:    palette = {z, z, f};
            3'd3:    palette = {f, f, f};
            3'd4:    palette = {z, z, z};
            3'd5:    palette = {f, f, z};
            3'd6:    palette = {f, z, f};
            default: palette = {z, f, f};
        endcase
    endfunction

    // Mode control and per-frame animation state.
    logic [2:0]         pending_mode;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [7:0]         frame_cnt;
    logic [11:0]        bar_pos;
    logic [12:0]        bar_sum;

    // Only frame_cnt[6:4] selects a colour; the rest just keeps counting.
    logic unused_frame_bits;
    assign unused_frame_bits = ^{frame_cnt[7], frame_cnt[3:0]};

    assign bar_sum = {1'b0, bar_pos} + BAR_STEP13;

    // Track the requested mode and latch it into cur_mode only at frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_mode <= 3'd0;
            cur_mode     <= 3'd0;
            dwell_cnt    <= '0;
        end else begin
            // Uses the pending value from before this edge; a same-cycle
            // step or expiry is picked up by the following frame_start.
            if (frame_start) begin
                cur_mode <= pending_mode;
            end
            if (!auto_en) begin
                pending_mode <= mode_sel;
                dwell_cnt    <= '0;
            end else if (mode_step) begin
                // A manual step wins over dwell expiry: one increment only.
                pending_mode <= pending_mode + 3'd1;
                dwell_cnt    <= '0;
            end else if (frame_start) begin
                if (dwell_cnt == DWELL_LAST) begin
                    pending_mode <= pending_mode + 3'd1;
                    dwell_cnt    <= '0;
                end else begin
                    dwell_cnt <= dwell_cnt + DWELL_W'(1);
                end
            end
        end
    end

    // Advance the frame counter and the moving-bar position once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
            bar_pos   <= 12'd0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (bar_sum >= H_LIM13) begin
                bar_pos <= 12'(bar_sum - H_LIM13);
            end else begin
                bar_pos <= bar_sum[11:0];
            end
        end
    end

    // Stage-1 region decode from the incoming coordinates.
    logic [2:0] v_idx;
    logic [2:0] h_idx;
    logic       in_range;
    logic       check_hit;
    logic       grid_hit;
    logic       bar_hit;

    // Decode bar index, range, checker, grid and moving-bar hits.
    always_comb begin
        v_idx = 3'd0;
        h_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (lcd_xpos >= 12'((H_DISP / 8) * k)) v_idx = 3'(k);
            if (lcd_ypos >= 12'((V_DISP / 8) * k)) h_idx = 3'(k);
        end
        in_range  = (lcd_xpos < H_LIM) && (lcd_ypos < V_LIM);
        check_hit = lcd_xpos[CHECK_LOG2] ^ lcd_ypos[CHECK_LOG2];
        grid_hit  = (lcd_xpos == 12'd0) || (lcd_xpos == H_LAST) ||
                    (lcd_ypos == 12'd0) || (lcd_ypos == V_LAST) ||
                    (lcd_xpos == H_MID) || (lcd_ypos == V_MID);
        // Bar is clipped by the range check, so no wrap term is needed.
        bar_hit   = ({1'b0, lcd_xpos} >= {1'b0, bar_pos}) &&
                    ({1'b0, lcd_xpos} <  ({1'b0, bar_pos} + BAR_W13));
    end

    logic        s1_de;
    logic [11:0] s1_x;
    logic [11:0] s1_y;
    logic [2:0]  s1_mode;
    logic        s1_in_range;
    logic [2:0]  s1_v_idx;
    logic [2:0]  s1_h_idx;
    logic        s1_check;
    logic        s1_grid;
    logic        s1_bar;
    logic [2:0]  s1_solid;

    // Stage 1: capture coordinates, DE and the frame state seen by this pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_de       <= 1'b0;
            s1_x        <= 12'd0;
            s1_y        <= 12'd0;
            s1_mode     <= 3'd0;
            s1_in_range <= 1'b0;
            s1_v_idx    <= 3'd0;
            s1_h_idx    <= 3'd0;
            s1_check    <= 1'b0;
            s1_grid     <= 1'b0;
            s1_bar      <= 1'b0;
            s1_solid    <= 3'd0;
        end else begin
            s1_de       <= lcd_de;
            s1_x        <= lcd_xpos;
            s1_y        <= lcd_ypos;
            s1_mode     <= cur_mode;
            s1_in_range <= in_range;
            s1_v_idx    <= v_idx;
            s1_h_idx    <= h_idx;
            s1_check    <= check_hit;
            s1_grid     <= grid_hit;
            s1_bar      <= bar_hit;
            s1_solid    <= frame_cnt[6:4];
        end
    end

    // Stage-2 colour selection.
    logic [23:0]       prod;
    logic [PROD_W-1:0] prod_w;
    logic [PIX_W-1:0]  pix_color;

    assign prod   = 24'(s1_x) * 24'(s1_y);
    assign prod_w = PROD_W'(prod);

    // Pick the colour for the stage-1 pixel according to its captured mode.
    always_comb begin
        pix_color = '0;
        if (s1_in_range) begin
            case (s1_mode)
                3'd0:    pix_color = palette(s1_v_idx);
                3'd1:    pix_color = palette(s1_h_idx);
                3'd2:    pix_color = {3{s1_x[COLOR_W-1:0]}};
                3'd3:    pix_color = s1_check ? palette(3'd3) : '0;
                3'd4:    pix_color = s1_grid ? palette(3'd3) : palette(3'd2);
                3'd5:    pix_color = prod_w[PIX_W-1:0];
                3'd6:    pix_color = s1_bar ? palette(3'd3) : '0;
                default: pix_color = palette(s1_solid);
            endcase
        end
    end

    // Stage 2: register the pixel; blank whenever DE is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_data     <= '0;
            lcd_data_vld <= 1'b0;
        end else begin
            lcd_data     <= s1_de ? pix_color : '0;
            lcd_data_vld <= s1_de;
        end
    end

endmodule
